// File: rtl/instr_encoder_loader.sv
// Encodes instruction descriptors into RV32I words and writes them sequentially
// into instruction memory while holding the core in reset.
module instr_encoder_loader #(
    parameter int unsigned ADDR_W     = 6,
    parameter int unsigned START_ADDR = 0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_class,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic              in_f7b5,
    input  logic [12:0]       in_imm,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_hold_n,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   count
);

    typedef enum logic [2:0] {StIdle, StAccept, StWrite, StDone, StErr} state_e;

    localparam logic [ADDR_W-1:0] StartAddr = ADDR_W'(START_ADDR);
    localparam logic [ADDR_W:0]   Capacity  = {1'b1, {ADDR_W{1'b0}}};

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W:0]     count_q;
    logic [31:0]         word_q;
    logic                last_q;
    logic [31:0]         enc_word;
    logic                enc_legal;
    logic                start_ok;
    logic                accept;

    always_comb begin
        enc_word  = '0;
        enc_legal = 1'b1;
        case (in_class)
            3'd0: enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0000011};
            3'd1: enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], 7'b0100011};
            3'd2: enc_word = {1'b0, in_f7b5, 5'b00000, in_rs2, in_rs1, in_funct3, in_rd,
                              7'b0110011};
            3'd3: enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0010011};
            3'd4: begin
                enc_word  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3, in_imm[4:1],
                             in_imm[11], 7'b1100011};
                // Branch offsets are halfword aligned; an odd offset cannot be encoded.
                enc_legal = ~in_imm[0];
            end
            default: enc_legal = 1'b0;
        endcase
    end

    assign start_ok = start && (state_q == StIdle || state_q == StDone || state_q == StErr);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle, StDone, StErr: if (start) state_d = StAccept;
            StAccept: begin
                if (count_q == Capacity) begin
                    state_d = StErr;
                end else if (in_valid) begin
                    state_d = enc_legal ? StWrite : StErr;
                end
            end
            StWrite: state_d = last_q ? StDone : StAccept;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            addr_q  <= StartAddr;
            count_q <= '0;
            word_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            if (start_ok) begin
                addr_q  <= StartAddr;
                count_q <= '0;
            end
            if (accept && enc_legal) begin
                word_q <= enc_word;
                last_q <= in_last;
            end
            if (state_q == StWrite) begin
                addr_q  <= addr_q + ADDR_W'(1);
                count_q <= count_q + (ADDR_W + 1)'(1);
            end
        end
    end

    always_comb begin
        // Memory full blocks the handshake so the ERR transition cannot race a write.
        in_ready    = (state_q == StAccept) && (count_q != Capacity);
        imem_we     = (state_q == StWrite);
        done        = (state_q == StDone);
        err         = (state_q == StErr);
        core_hold_n = !(state_q == StAccept || state_q == StWrite || state_q == StErr);
    end

    assign imem_addr  = addr_q;
    assign imem_wdata = word_q;
    assign count      = count_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: encodings, sessions, errors, capacity
// and asynchronous reset during a write.
module tb_instr_encoder_loader;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_class = '0;
    logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
    logic [2:0]  in_funct3 = '0;
    logic        in_f7b5 = 1'b0;
    logic [12:0] in_imm = '0;
    logic        in_last = 1'b0;
    logic        imem_we;
    logic [5:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        core_hold_n, done, err;
    logic [6:0]  count;

    logic        s_start = 1'b0;
    logic        s_in_valid = 1'b0;
    logic        s_in_ready;
    logic        s_imem_we;
    logic [1:0]  s_imem_addr;
    logic [31:0] s_imem_wdata;
    logic        s_core_hold_n, s_done, s_err;
    logic [2:0]  s_count;

    int tests = 0;
    int fails = 0;

    always #5 CLK = ~CLK;

    instr_encoder_loader #(.ADDR_W(6), .START_ADDR(0)) dut (
        .CLK(CLK), .RST(RST), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_class(in_class), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_f7b5(in_f7b5), .in_imm(in_imm), .in_last(in_last),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .core_hold_n(core_hold_n), .done(done), .err(err), .count(count)
    );

    instr_encoder_loader #(.ADDR_W(2), .START_ADDR(0)) dut_small (
        .CLK(CLK), .RST(RST), .start(s_start), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_class(3'd3), .in_rd(5'd1), .in_rs1(5'd0), .in_rs2(5'd0),
        .in_funct3(3'd0), .in_f7b5(1'b0), .in_imm(13'd5), .in_last(1'b0),
        .imem_we(s_imem_we), .imem_addr(s_imem_addr), .imem_wdata(s_imem_wdata),
        .core_hold_n(s_core_hold_n), .done(s_done), .err(s_err), .count(s_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge CLK);
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (in_ready !== 1'b1 && n < 10) begin
            @(negedge CLK);
            n++;
        end
        chk("ready_wait", 32'(in_ready), 32'd1);
    endtask

    // Handshake one descriptor; in_valid stays high through WRITE to show no second accept.
    task automatic send(input logic [2:0] cls, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic f7,
                        input logic [12:0] imm, input logic last,
                        input logic [31:0] exp_w, input logic [5:0] exp_a);
        wait_ready();
        in_class = cls; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_f7b5 = f7; in_imm = imm; in_last = last;
        in_valid = 1'b1;
        @(negedge CLK);
        chk("we", 32'(imem_we), 32'd1);
        chk("wdata", imem_wdata, exp_w);
        chk("addr", 32'(imem_addr), 32'(exp_a));
        chk("ready_in_write", 32'(in_ready), 32'd0);
        @(negedge CLK);
        in_valid = 1'b0;
        chk("we_single_cycle", 32'(imem_we), 32'd0);
    endtask

    initial begin
        @(negedge CLK);
        @(negedge CLK);
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_we", 32'(imem_we), 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'd0);
        chk("rst_wdata", imem_wdata, 32'd0);
        chk("rst_hold_n", 32'(core_hold_n), 32'd1);
        chk("rst_done_err", {30'd0, done, err}, 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        RST = 1'b1;

        pulse_start();
        chk("s1_hold_n", 32'(core_hold_n), 32'd0);
        send(3'd0, 5'd6, 5'd9, 5'd0, 3'b010, 1'b0, 13'h1FFC, 1'b0, 32'hFFC4A303, 6'd0);
        send(3'd1, 5'd0, 5'd9, 5'd6, 3'b010, 1'b0, 13'd8, 1'b0, 32'h0064A423, 6'd1);
        send(3'd2, 5'd3, 5'd1, 5'd2, 3'b000, 1'b0, 13'd0, 1'b0, 32'h002081B3, 6'd2);
        send(3'd2, 5'd3, 5'd1, 5'd2, 3'b000, 1'b1, 13'd0, 1'b0, 32'h402081B3, 6'd3);
        send(3'd3, 5'd1, 5'd0, 5'd0, 3'b000, 1'b1, 13'd5, 1'b1, 32'h00500093, 6'd4);
        chk("s1_done", 32'(done), 32'd1);
        chk("s1_hold_n_rel", 32'(core_hold_n), 32'd1);
        chk("s1_count", 32'(count), 32'd5);
        chk("s1_ready_done", 32'(in_ready), 32'd0);

        pulse_start();
        chk("s2_done_clr", 32'(done), 32'd0);
        chk("s2_count_clr", 32'(count), 32'd0);
        chk("s2_addr_clr", 32'(imem_addr), 32'd0);
        send(3'd4, 5'd0, 5'd1, 5'd2, 3'b000, 1'b0, 13'h1FF8, 1'b1, 32'hFE208CE3, 6'd0);
        chk("s2_done", 32'(done), 32'd1);
        chk("s2_count", 32'(count), 32'd1);

        pulse_start();
        wait_ready();
        in_class = 3'd6; in_last = 1'b0; in_valid = 1'b1;
        @(negedge CLK);
        in_valid = 1'b0;
        chk("ill_err", 32'(err), 32'd1);
        chk("ill_we", 32'(imem_we), 32'd0);
        chk("ill_hold_n", 32'(core_hold_n), 32'd0);
        chk("ill_ready", 32'(in_ready), 32'd0);
        @(negedge CLK);
        chk("ill_err_hold", 32'(err), 32'd1);
        chk("ill_count", 32'(count), 32'd0);

        pulse_start();
        chk("rec_err_clr", 32'(err), 32'd0);
        wait_ready();
        in_class = 3'd4; in_imm = 13'd3; in_valid = 1'b1;
        @(negedge CLK);
        in_valid = 1'b0;
        chk("odd_br_err", 32'(err), 32'd1);
        chk("odd_br_we", 32'(imem_we), 32'd0);
        pulse_start();
        chk("rec2_err_clr", 32'(err), 32'd0);
        chk("rec2_ready", 32'(in_ready), 32'd1);

        // Four-word memory: fifth descriptor must be refused.
        @(negedge CLK);
        s_start = 1'b1;
        @(negedge CLK);
        s_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("cap_ready", 32'(s_in_ready), 32'd1);
            s_in_valid = 1'b1;
            @(negedge CLK);
            chk("cap_we", 32'(s_imem_we), 32'd1);
            chk("cap_addr", 32'(s_imem_addr), 32'(i));
            @(negedge CLK);
            s_in_valid = 1'b0;
        end
        chk("cap_full_ready", 32'(s_in_ready), 32'd0);
        s_in_valid = 1'b1;
        @(negedge CLK);
        s_in_valid = 1'b0;
        chk("cap_err", 32'(s_err), 32'd1);
        chk("cap_no_we", 32'(s_imem_we), 32'd0);
        chk("cap_count", 32'(s_count), 32'd4);
        chk("cap_hold_n", 32'(s_core_hold_n), 32'd0);

        // Main DUT is in ACCEPT; reset asynchronously in the middle of WRITE.
        in_class = 3'd0; in_imm = 13'h1FFC; in_rd = 5'd6; in_rs1 = 5'd9;
        in_funct3 = 3'b010; in_last = 1'b0; in_valid = 1'b1;
        @(negedge CLK);
        chk("mid_we", 32'(imem_we), 32'd1);
        #2 RST = 1'b0;
        #1;
        chk("mid_rst_we", 32'(imem_we), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd0);
        chk("mid_rst_hold_n", 32'(core_hold_n), 32'd1);
        chk("mid_rst_addr", 32'(imem_addr), 32'd0);
        chk("mid_rst_wdata", imem_wdata, 32'd0);
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_done_err", {30'd0, done, err}, 32'd0);
        in_valid = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        chk("post_rst_idle_ready", 32'(in_ready), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
